sof_detect: RTL and testbench

- Receiver-side start-of-frame detector for the PPM link; the counterpart of the transmitter's SOF generator.
- Synchronises the incoming PPM line, qualifies a rising edge, then samples SOF_BITS fixed-length slots at mid-slot and compares them with SOF_PATTERN.
- On a full match it pulses sof_detected and holds sof_locked until the frame logic releases it. On any mismatch it aborts, counts an error and re-arms.
- Sits between the line input and the PPM symbol decoder, which starts slot timing from sof_detected.

---
 rtl/sof_detect.sv | 115 +++++++++++
 tb/tb_sof_detect.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sof_detect.sv
// Start-of-frame detector for the PPM link: synchronises the line, triggers on a
// rising edge, samples each SOF slot at mid-slot and locks on a full pattern match.
module sof_detect #(
  parameter int                  SOF_BITS    = 8,
  parameter logic [SOF_BITS-1:0] SOF_PATTERN = 8'b1011_0010,
  parameter int                  SLOT_CYCLES = 4,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ppm_in,
  input  logic       lock_clear,
  output logic       sof_detected,
  output logic       sof_locked,
  output logic       sof_error,
  output logic       busy,
  output logic [7:0] err_cnt
);

  // state   | meaning
  // ARM     | wait for the line to be low before accepting a new edge
  // IDLE    | line low, waiting for a rising edge
  // SAMPLE  | sampling SOF slots at mid-slot
  // LOCKED  | pattern matched, held until lock_clear
  typedef enum logic [1:0] {ARM, IDLE, SAMPLE, LOCKED} state_t;

  localparam int SW   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW   = (SOF_BITS > 1) ? $clog2(SOF_BITS) : 1;
  localparam int HALF = SLOT_CYCLES / 2;

  if (SOF_PATTERN[SOF_BITS-1] != 1'b1 || SLOT_CYCLES < 2) begin : g_bad_params
    $error("sof_detect: SOF_PATTERN MSB must be 1 and SLOT_CYCLES must be >= 2");
  end

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_s, line_p, rise;
  logic [SW-1:0]          slot_cnt;
  logic [BW-1:0]          bit_idx;
  logic                   sample_pt, pat_bit;
  logic                   det_set, err_set, det_q, err_q;

  assign line_s    = sync_q[SYNC_STAGES-1];
  assign rise      = line_s & ~line_p;
  // slot_cnt is 0 in the cycle after the edge, so mid-slot lands one count early
  assign sample_pt = (slot_cnt == SW'(HALF - 1));
  assign pat_bit   = SOF_PATTERN[bit_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARM;
      sync_q   <= '0;
      line_p   <= 1'b0;
      slot_cnt <= '0;
      bit_idx  <= '0;
      det_q    <= 1'b0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state  <= state_n;
      sync_q <= {sync_q[SYNC_STAGES-2:0], ppm_in};
      line_p <= line_s;
      det_q  <= det_set;
      err_q  <= err_set;
      if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (state == IDLE && state_n == SAMPLE) begin
        slot_cnt <= '0;
        bit_idx  <= BW'(SOF_BITS - 1);
      end else if (state == SAMPLE) begin
        if (slot_cnt == SW'(SLOT_CYCLES - 1)) begin
          slot_cnt <= '0;
          bit_idx  <= bit_idx - BW'(1);
        end else begin
          slot_cnt <= slot_cnt + SW'(1);
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    det_set = 1'b0;
    err_set = 1'b0;
    if (!en) begin
      state_n = ARM;
    end else begin
      case (state)
        ARM:    if (!line_s) state_n = IDLE;
        IDLE:   if (rise) state_n = SAMPLE;
        SAMPLE: begin
          if (sample_pt) begin
            if (line_s != pat_bit) begin
              state_n = ARM;
              err_set = 1'b1;
            end else if (bit_idx == '0) begin
              state_n = LOCKED;
              det_set = 1'b1;
            end
          end
        end
        LOCKED: if (lock_clear) state_n = ARM;
        default: state_n = ARM;
      endcase
    end
  end

  always_comb begin
    busy         = (state == SAMPLE);
    sof_locked   = (state == LOCKED);
    sof_detected = det_q;
    sof_error    = err_q;
  end

endmodule

// File: tb/tb_sof_detect.sv
// Bench for sof_detect: directed and random line patterns checked every cycle
// against a slot-timing reference model, plus targeted latency/saturation checks.
module tb_sof_detect;
  localparam int          SB  = 8;
  localparam logic [7:0]  PAT = 8'b1011_0010;
  localparam int          SC  = 4;
  localparam int          SS  = 2;
  localparam int          H   = SC / 2;
  localparam int M_ARM = 0, M_IDLE = 1, M_SAMP = 2, M_LOCK = 3;

  logic clk = 1'b0, rst, en, ppm_in, lock_clear;
  logic sof_detected, sof_locked, sof_error, busy;
  logic [7:0] err_cnt;

  int total = 0, bad = 0, cyc = 0;
  int det_seen = 0, err_seen = 0, last_det_cyc = -1;

  // reference model
  logic q_line[$];
  logic m_lp;
  int   m_mode, m_n, m_cnt;
  logic exp_det, exp_err, exp_busy, exp_lock;
  logic [7:0] exp_cnt;

  sof_detect #(.SOF_BITS(SB), .SOF_PATTERN(PAT), .SLOT_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .en(en), .ppm_in(ppm_in), .lock_clear(lock_clear),
    .sof_detected(sof_detected), .sof_locked(sof_locked), .sof_error(sof_error),
    .busy(busy), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Advances the model across one clock edge given this cycle's inputs.
  task automatic model_step(input logic p, input logic e, input logic lc, input logic r);
    logic ls, lp;
    int k;
    ls = q_line[0];
    lp = m_lp;
    exp_det = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      m_mode = M_ARM; m_cnt = 0; m_lp = 1'b0;
      q_line = {};
      for (int i = 0; i < SS; i++) q_line.push_back(1'b0);
    end else begin
      m_lp = ls;
      void'(q_line.pop_front());
      q_line.push_back(p);
      if (!e) m_mode = M_ARM;
      else begin
        case (m_mode)
          M_ARM:  if (!ls) m_mode = M_IDLE;
          M_IDLE: if (ls && !lp) begin m_mode = M_SAMP; m_n = 1; end
          M_SAMP: begin
            if (m_n >= H && (m_n - H) % SC == 0) begin
              k = (m_n - H) / SC;
              if (ls != PAT[SB-1-k]) begin
                m_mode = M_ARM; exp_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
              end else if (k == SB - 1) begin
                m_mode = M_LOCK; exp_det = 1'b1;
              end
            end
            m_n++;
          end
          default: if (lc) m_mode = M_ARM;
        endcase
      end
    end
    exp_busy = (m_mode == M_SAMP);
    exp_lock = (m_mode == M_LOCK);
    exp_cnt  = 8'(m_cnt);
  endtask

  task automatic tick(input logic p, input logic e, input logic lc, input logic r);
    @(negedge clk);
    expect_eq("sof_detected", int'(sof_detected), int'(exp_det));
    expect_eq("sof_locked",   int'(sof_locked),   int'(exp_lock));
    expect_eq("sof_error",    int'(sof_error),    int'(exp_err));
    expect_eq("busy",         int'(busy),         int'(exp_busy));
    expect_eq("err_cnt",      int'(err_cnt),      int'(exp_cnt));
    if (sof_detected === 1'b1) begin det_seen++; last_det_cyc = cyc; end
    if (sof_error === 1'b1) err_seen++;
    ppm_in = p; en = e; lock_clear = lc; rst = r;
    model_step(p, e, lc, r);
    cyc++;
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Sends one slot-per-bit frame; en is held low from tick drop_at onwards when drop_at >= 0.
  task automatic send_frame(input logic [7:0] pat, input int drop_at, output int c0);
    logic e;
    c0 = cyc;
    for (int i = 0; i < SB * SC; i++) begin
      e = !(drop_at >= 0 && i >= drop_at);
      tick(pat[SB-1-(i/SC)], e, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int c0, d0, e0, cnt0;
    logic [7:0] pat;
    rst = 1'b1; en = 1'b0; ppm_in = 1'b0; lock_clear = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b1);

    // reset with a toggling line, then quiet
    for (int i = 0; i < 3; i++) tick(1'(i % 2), 1'b0, 1'b0, 1'b1);
    idle_low(10);
    expect_eq("no_pulse_after_reset", det_seen + err_seen, 0);

    // clean SOF, latency, lock_clear, repeat
    for (int rep = 0; rep < 2; rep++) begin
      d0 = det_seen;
      send_frame(PAT, -1, c0);
      idle_low(6);
      expect_eq("clean_det_count", det_seen - d0, 1);
      expect_eq("clean_det_cycle", last_det_cyc, c0 + SS + (SB - 1) * SC + H + 1);
      expect_eq("clean_locked", int'(sof_locked), 1);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      expect_eq("locked_released", int'(sof_locked), 0);
      idle_low(4);
    end
    expect_eq("clean_err_cnt", int'(err_cnt), 0);

    // corrupted pattern, then a valid one
    d0 = det_seen; e0 = err_seen;
    send_frame(8'b1011_1010, -1, c0);
    idle_low(8);
    expect_eq("corrupt_no_det", det_seen - d0, 0);
    expect_eq("corrupt_err_seen", int'(err_seen > e0), 1);
    send_frame(PAT, -1, c0);
    idle_low(6);
    expect_eq("after_corrupt_det", det_seen - d0, 1);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    idle_low(4);

    // single glitch
    e0 = err_seen; cnt0 = int'(err_cnt);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    idle_low(6);
    expect_eq("glitch_err", err_seen - e0, 1);
    expect_eq("glitch_cnt", int'(err_cnt), cnt0 + 1);

    // saturation
    for (int g = 0; g < 300; g++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle_low(6);
    end
    expect_eq("err_cnt_saturated", int'(err_cnt), 255);

    // stuck-high line after reset, then a valid SOF
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    e0 = err_seen; d0 = det_seen;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("stuck_no_det", det_seen - d0, 0);
    idle_low(5);
    send_frame(PAT, -1, c0);
    idle_low(6);
    expect_eq("stuck_err_at_most_1", int'(err_seen - e0 <= 1), 1);
    expect_eq("stuck_then_det", det_seen - d0, 1);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    idle_low(4);

    // en dropped at E+12 for the rest of the frame
    e0 = err_seen; cnt0 = int'(err_cnt); d0 = det_seen;
    send_frame(PAT, SS + 12, c0);
    expect_eq("en_drop_busy", int'(busy), 0);
    idle_low(6);
    expect_eq("en_drop_no_err", err_seen - e0, 0);
    expect_eq("en_drop_cnt_hold", int'(err_cnt), cnt0);
    expect_eq("en_drop_no_det", det_seen - d0, 0);

    // reset while locked
    send_frame(PAT, -1, c0);
    idle_low(6);
    expect_eq("pre_reset_locked", int'(sof_locked), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    expect_eq("reset_clears_lock", int'(sof_locked), 0);
    idle_low(4);

    // random frames with random en drops and lock_clear pulses
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: pat = PAT;
        2:    pat = PAT ^ (8'd1 << $urandom_range(0, SB - 2));
        default: pat = 8'($urandom) | 8'h80;
      endcase
      for (int i = 0; i < SB * SC; i++)
        tick(pat[SB-1-(i/SC)], 1'($urandom_range(0, 39) != 0),
             1'($urandom_range(0, 14) == 0), 1'b0);
      for (int i = 0; i < int'($urandom_range(2, 8)); i++)
        tick(1'b0, 1'b1, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    idle_low(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
